axis_width_conv_wide_narrow: RTL
================================

Name: axis_width_conv_wide_narrow

Overview:
Splits each M-bit wide stream word into M/N consecutive N-bit narrow words, most significant slice first. It is the mirror of the narrow-to-wide converter and uses the same tnext/tvalid/tfirst handshake. The block sits at the egress of wide datapaths that feed narrow serializers or links. A two-page ping-pong buffer lets the block emit one narrow word per cycle with no bubbles.

Parameters:
M, 8, input (wide) data width in bits; must be an integer multiple of N.
N, 4, output (narrow) data width in bits.
KN (localparam), M/N, slices per wide word; must be ≥ 2.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
s_axis_tnext  out  1  upstream word consumed this cycle
s_axis_tdata  in  M  wide input data
s_axis_tfirst  in  1  input word is frame start
s_axis_tvalid  in  1  input word valid
m_axis_tnext  in  1  downstream consumes current narrow word this cycle
m_axis_tdata  out  N  narrow output data
m_axis_tfirst  out  1  output slice is first slice of a frame-start word
m_axis_tvalid  out  1  output word valid
bit_count  out  16  bits held in buffer and not yet emitted

Behaviour:
- Reset (rst=0 at a clock edge):
  - Both pages are emptied and page contents are cleared to 0.
  - wr_page=0, rd_page=0, rd_ptr=KN-1.
  - While rst=0: s_axis_tnext=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tfirst=0, bit_count=0.
- Mid-operation reset discards all buffered data and emits no partial slices. The first word after reset starts at its MSB slice.
- Elaboration checks: M%N≠0 or KN=1 raises $error and $finish.
- Storage: 2 pages of M bits, plus one tfirst bit per page.
  - Each page has an occupied flag, or equivalently extended wr/rd page pointers as used in narrow_wide.
  - full = both pages occupied; empty = no page occupied. Both are computed from registered state only.
- Write side:
  - s_axis_tnext = s_axis_tvalid && !full && rst. This is the only combinational input-to-output path.
  - On s_axis_tnext, the page at wr_page latches s_axis_tdata and s_axis_tfirst, is marked occupied, and wr_page toggles.
- Read side:
  - m_axis_tvalid = !empty.
  - m_axis_tdata = page[rd_page][rd_ptr*N+N-1 -: N].
  - m_axis_tfirst = page_first[rd_page] && (rd_ptr==KN-1).
  - All read outputs are driven from registers; there is no combinational path from the s_* inputs.
- On m_axis_tnext && m_axis_tvalid:
  - If rd_ptr≠0: rd_ptr decrements.
  - If rd_ptr=0: rd_ptr=KN-1, the read page is freed, and rd_page toggles.
- m_axis_tnext while m_axis_tvalid=0 is ignored.
- Latency: a word accepted at edge t gives m_axis_tvalid=1 with its MSB slice after edge t, i.e. it is visible in cycle t+1.
- Throughput: one narrow word per cycle sustained; one wide word accepted per KN cycles at steady state.
- Simultaneous events:
  - Write and read in the same cycle are both performed.
  - When the buffer is full and the final slice of the read page is consumed in a cycle, the write is NOT accepted that cycle, because full is registered. It is accepted in the next cycle, and no output bubble results.
- bit_count = M*(occupied pages) − N*(KN-1-rd_ptr) when a page is occupied, else 0. It is derived from registered state, zero-extended to 16 bits, and updates one cycle after a handshake.
- tfirst is a pure side-band tag: no frame checking and no error state.

Decomposition:
- Package axis_wc_pkg holds:
  - the shared tnext/tvalid/tfirst handshake conventions;
  - the clog2-based width helper localparams;
  - the parameter-check macro/function used by both width converters.
- The register_t struct (pages, page_first, occupancy/ext bits, wr_page, rd_page, rd_ptr) is local to the module.
- Single module; no sub-module is warranted.

Test Plan:
1. rst=0 held 5 cycles with s_axis_tvalid=1, data=0xFF → s_axis_tnext=0, m_axis_tvalid=0, m_axis_tdata=0, bit_count=0 throughout.
2. Single word 0xA5 with tfirst=1, m_axis_tnext=1 → next cycle data=0xA tfirst=1; following cycle data=0x5 tfirst=0; then tvalid=0. bit_count reads 8, 4, 0.
3. Backpressure, m_axis_tnext=0, offer 0x12, 0x34, 0x56 back-to-back → first two accepted, s_axis_tnext=0 for 0x56, bit_count=16. Release tnext → outputs 1,2,3,4 then 5,6. 0x56 is accepted the cycle after the 0x12 page frees.
4. Continuous tvalid/tnext with words 0x01..0x10 → outputs 0,1,0,2,…,1,0 with m_axis_tvalid held 1 (no bubbles) after the first word. s_axis_tnext pulses every 2nd cycle at steady state.
5. Reset mid-stream: after 2 words accepted and 1 slice emitted, rst=0 for 1 cycle → all outputs 0. Next word 0xC3 emits 0xC then 0x3.
6. M=8, N=3 elaboration → $error and $finish. M=16, N=4, word 0x1234 → emits 1,2,3,4 with tfirst only on 1.

Source files
------------

// File: rtl/axis_wc_pkg.sv
// Shared definitions for the AXI-stream width converters.
// Handshake: source raises tvalid, sink pulses tnext when it takes the word.
package axis_wc_pkg;

    // Width of the bit_count status port on both converters.
    localparam int unsigned BIT_COUNT_W = 16;

    // Slice-pointer width; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned kn);
        return (kn < 2) ? 1 : $clog2(kn);
    endfunction

    // Wide width must be a whole number (>= 2) of narrow slices.
    function automatic bit widths_ok(input int unsigned m,
                                     input int unsigned n);
        return (n != 0) && (m % n == 0) && (m / n >= 2);
    endfunction

endpackage

// File: rtl/axis_width_conv_wide_narrow.sv
// Wide-to-narrow stream converter: each M-bit word leaves as M/N N-bit
// slices, MSB slice first, through a two-page ping-pong buffer.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   s_axis_*            wide input  (tdata M, tfirst, tvalid, tnext out)
//   m_axis_*            narrow output (tdata N, tfirst, tvalid, tnext in)
//   bit_count           buffered bits not yet emitted
module axis_width_conv_wide_narrow
    import axis_wc_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   s_axis_tnext,
    input  logic [M-1:0]           s_axis_tdata,
    input  logic                   s_axis_tfirst,
    input  logic                   s_axis_tvalid,
    input  logic                   m_axis_tnext,
    output logic [N-1:0]           m_axis_tdata,
    output logic                   m_axis_tfirst,
    output logic                   m_axis_tvalid,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    localparam int unsigned KN = M / N;
    localparam int unsigned PW = ptr_width(KN);
    localparam logic [PW-1:0] PTR_TOP = PW'(KN - 1);

    if (!widths_ok(M, N)) begin : g_bad_widths
        $error("axis_width_conv_wide_narrow: M must be a multiple of N with M/N >= 2");
    end

    typedef struct packed {
        logic [1:0][M-1:0] page;
        logic [1:0]        first;
        logic [1:0]        occ;
        logic              wr_page;
        logic              rd_page;
        logic [PW-1:0]     rd_ptr;
    } register_t;

    localparam register_t R_RST = '{
        page:    '0,
        first:   '0,
        occ:     '0,
        wr_page: 1'b0,
        rd_page: 1'b0,
        rd_ptr:  PTR_TOP
    };

    register_t r_q, r_d;

    logic full, empty;
    logic wr_fire, rd_fire;
    logic [KN-1:0][N-1:0] rd_slices;
    logic [BIT_COUNT_W-1:0] held_bits, sent_bits;

    // Occupancy comes only from flops, so a page freed this cycle is
    // refilled next cycle; the second page covers the gap.
    assign full  = &r_q.occ;
    assign empty = ~|r_q.occ;

    assign s_axis_tnext  = s_axis_tvalid && !full && rst;
    assign m_axis_tvalid = !empty && rst;

    assign wr_fire = s_axis_tnext;
    assign rd_fire = m_axis_tnext && m_axis_tvalid;

    assign rd_slices     = r_q.page[r_q.rd_page];
    assign m_axis_tdata  = rst ? rd_slices[r_q.rd_ptr] : '0;
    assign m_axis_tfirst = rst && r_q.first[r_q.rd_page]
                               && (r_q.rd_ptr == PTR_TOP);

    // Bits in occupied pages minus slices already sent from the read page.
    assign held_bits = BIT_COUNT_W'(M)
                     * BIT_COUNT_W'({1'b0, r_q.occ[0]} + {1'b0, r_q.occ[1]});
    assign sent_bits = BIT_COUNT_W'(N) * BIT_COUNT_W'(PTR_TOP - r_q.rd_ptr);
    assign bit_count = (rst && !empty) ? held_bits - sent_bits : '0;

    always_comb begin
        r_d = r_q;
        if (wr_fire) begin
            r_d.page[r_q.wr_page]  = s_axis_tdata;
            r_d.first[r_q.wr_page] = s_axis_tfirst;
            r_d.occ[r_q.wr_page]   = 1'b1;
            r_d.wr_page            = ~r_q.wr_page;
        end
        // A write never targets the read page while it is occupied.
        if (rd_fire) begin
            if (r_q.rd_ptr != '0) begin
                r_d.rd_ptr = r_q.rd_ptr - 1'b1;
            end else begin
                r_d.rd_ptr           = PTR_TOP;
                r_d.occ[r_q.rd_page] = 1'b0;
                r_d.rd_page          = ~r_q.rd_page;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= R_RST;
        end else begin
            r_q <= r_d;
        end
    end

endmodule
